// File: rtl/decode_onehot_pipe_if.sv
// rtl/decode_onehot_pipe_if.sv - request/result handshake bundle for decode_onehot_pipe
interface decode_onehot_pipe_if #(
  parameter int N    = 3,
  parameter int M    = 8,
  parameter int CNTW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    sel;
  logic            value;
  logic            clr;
  logic            out_valid;
  logic            out_ready;
  logic [M-1:0]    dec;
  logic            err;
  logic [CNTW-1:0] err_cnt;

  modport master (
    output in_valid, sel, value, clr, out_ready,
    input  in_ready, out_valid, dec, err, err_cnt
  );

  modport slave (
    input  in_valid, sel, value, clr, out_ready,
    output in_ready, out_valid, dec, err, err_cnt
  );
endinterface

// File: rtl/decode_onehot_pipe.sv
// rtl/decode_onehot_pipe.sv - registered select-to-one-hot decoder with pulse/sticky modes
module decode_onehot_pipe #(
  parameter int N      = 3,
  parameter int M      = 8,
  parameter int ACTIVE = 1,
  parameter int MODE   = 0,
  parameter int CNTW   = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  decode_onehot_pipe_if.slave bus
);
  // M can equal 2^N, so the limit needs one bit more than sel
  localparam logic [N:0] M_LIM = (N+1)'(M);

  logic            in_ready;
  logic            accept;
  logic            in_range;
  logic            out_valid_q;
  logic            err_q;
  logic [M-1:0]    v;
  logic [M-1:0]    acc_q;
  logic [CNTW-1:0] cnt_q;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign in_range = {1'b0, bus.sel} < M_LIM;

  always_comb begin
    v = '0;
    for (int i = 0; i < M; i++) begin
      if (accept && bus.value && bus.sel == N'(i)) v[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (accept) out_valid_q <= 1'b1;
      else if (bus.out_ready) out_valid_q <= 1'b0;

      // Sticky accumulates every cycle; pulse follows the handshake and idles at zero
      if (MODE != 0) acc_q <= (bus.clr ? '0 : acc_q) | v;
      else if (accept) acc_q <= v;
      else if (out_valid_q && bus.out_ready) acc_q <= '0;

      if (accept) err_q <= !in_range;
      if (accept && !in_range && cnt_q != '1) cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.dec       = (ACTIVE != 0) ? acc_q : ~acc_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = cnt_q;
endmodule

// File: tb/tb_decode_onehot_pipe.sv
// tb/tb_decode_onehot_pipe.sv - scoreboard bench for decode_onehot_pipe across four configurations
module tb_decode_onehot_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic sb_en = 1'b0;
  logic [7:0] sb_q[$];
  logic [7:0] sb_exp;

  decode_onehot_pipe_if #(.N(3), .M(8), .CNTW(8)) pu ();
  decode_onehot_pipe_if #(.N(3), .M(8), .CNTW(8)) st ();
  decode_onehot_pipe_if #(.N(3), .M(6), .CNTW(8)) m6 ();
  decode_onehot_pipe_if #(.N(3), .M(6), .CNTW(2)) c2 ();

  decode_onehot_pipe #(.N(3), .M(8), .ACTIVE(1), .MODE(0), .CNTW(8)) u_pulse (.clk(clk), .rst_n(rst_n), .bus(pu));
  decode_onehot_pipe #(.N(3), .M(8), .ACTIVE(0), .MODE(1), .CNTW(8)) u_sticky (.clk(clk), .rst_n(rst_n), .bus(st));
  decode_onehot_pipe #(.N(3), .M(6), .ACTIVE(1), .MODE(0), .CNTW(8)) u_m6 (.clk(clk), .rst_n(rst_n), .bus(m6));
  decode_onehot_pipe #(.N(3), .M(6), .ACTIVE(1), .MODE(0), .CNTW(2)) u_c2 (.clk(clk), .rst_n(rst_n), .bus(c2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse-mode scoreboard: push on accept, pop when the consumer takes the result
  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      check("in_ready", {31'd0, pu.in_ready}, {31'd0, (!pu.out_valid || pu.out_ready)});
      if (pu.out_valid && pu.out_ready) begin
        if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          sb_exp = sb_q.pop_front();
          check("sb_dec", {24'd0, pu.dec}, {24'd0, sb_exp});
        end
      end
      if (!pu.out_valid) check("sb_idle_dec", {24'd0, pu.dec}, 32'd0);
      if (pu.in_valid && (!pu.out_valid || pu.out_ready))
        sb_q.push_back(pu.value ? 8'(1 << pu.sel) : 8'h00);
    end
  end

  initial begin
    {pu.in_valid, pu.sel, pu.value, pu.clr} = '0; pu.out_ready = 1'b1;
    {st.in_valid, st.sel, st.value, st.clr} = '0; st.out_ready = 1'b1;
    {m6.in_valid, m6.sel, m6.value, m6.clr} = '0; m6.out_ready = 1'b1;
    {c2.in_valid, c2.sel, c2.value, c2.clr} = '0; c2.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_dec", {24'd0, pu.dec}, 32'h00);
    check("rst_out_valid", {31'd0, pu.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, pu.in_ready}, 32'd1);
    check("rst_err_cnt", {24'd0, pu.err_cnt}, 32'd0);
    check("rst_sticky_dec", {24'd0, st.dec}, 32'hFF);

    // Pulse: single decode then return to idle
    sb_en = 1'b1;
    step(); pu.in_valid = 1'b1; pu.sel = 3'd5; pu.value = 1'b1;
    step(); pu.in_valid = 1'b0;
    @(negedge clk);
    check("pulse_dec", {24'd0, pu.dec}, 32'h20);
    check("pulse_valid", {31'd0, pu.out_valid}, 32'd1);
    step();
    @(negedge clk);
    check("pulse_idle_dec", {24'd0, pu.dec}, 32'h00);
    check("pulse_idle_valid", {31'd0, pu.out_valid}, 32'd0);

    // Backpressure holds result and stalls input
    step(); pu.in_valid = 1'b1; pu.sel = 3'd2;
    step(); pu.sel = 3'd6; pu.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_dec", {24'd0, pu.dec}, 32'h04);
      check("bp_in_ready", {31'd0, pu.in_ready}, 32'd0);
      step();
    end
    pu.out_ready = 1'b1;
    step(); pu.in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_dec", {24'd0, pu.dec}, 32'h40);
    check("bp_next_valid", {31'd0, pu.out_valid}, 32'd1);

    // Random traffic through the scoreboard
    for (int i = 0; i < 150; i++) begin
      step();
      pu.in_valid  = 1'($urandom_range(0, 1));
      pu.sel       = 3'($urandom_range(0, 7));
      pu.value     = ($urandom_range(0, 3) != 0);
      pu.out_ready = ($urandom_range(0, 3) != 0);
    end
    step(); pu.in_valid = 1'b0; pu.out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    sb_en = 1'b0;
    check("sb_drained", sb_q.size(), 32'd0);

    // Sticky, active-low
    step(); st.in_valid = 1'b1; st.sel = 3'd1; st.value = 1'b1;
    step(); st.sel = 3'd3;
    step(); st.in_valid = 1'b0;
    @(negedge clk);
    check("sticky_acc", {24'd0, st.dec}, 32'hF5);
    step(); st.in_valid = 1'b1; st.sel = 3'd7; st.clr = 1'b1;
    step(); st.in_valid = 1'b0; st.clr = 1'b0; st.out_ready = 1'b0;
    @(negedge clk);
    check("sticky_clr_set", {24'd0, st.dec}, 32'h7F);
    check("sticky_valid", {31'd0, st.out_valid}, 32'd1);
    step(); st.clr = 1'b1;
    step(); st.clr = 1'b0;
    @(negedge clk);
    check("sticky_clr_only_valid", {31'd0, st.out_valid}, 32'd1);
    check("sticky_clr_only_dec", {24'd0, st.dec}, 32'hFF);
    step(); st.out_ready = 1'b1;
    step();
    @(negedge clk);
    check("sticky_drained_valid", {31'd0, st.out_valid}, 32'd0);

    // M=6 out-of-range handling
    step(); m6.in_valid = 1'b1; m6.sel = 3'd6; m6.value = 1'b1;
    step(); m6.sel = 3'd7; m6.value = 1'b0;
    @(negedge clk);
    check("m6_err_first", {31'd0, m6.err}, 32'd1);
    check("m6_cnt_first", {24'd0, m6.err_cnt}, 32'd1);
    step(); m6.in_valid = 1'b0;
    @(negedge clk);
    check("m6_err", {31'd0, m6.err}, 32'd1);
    check("m6_err_cnt", {24'd0, m6.err_cnt}, 32'd2);
    check("m6_dec_none", {26'd0, m6.dec}, 32'h00);
    step(); m6.in_valid = 1'b1; m6.sel = 3'd0; m6.value = 1'b1;
    step(); m6.in_valid = 1'b0;
    @(negedge clk);
    check("m6_err_clear", {31'd0, m6.err}, 32'd0);
    check("m6_dec_in_range", {26'd0, m6.dec}, 32'h01);
    check("m6_cnt_kept", {24'd0, m6.err_cnt}, 32'd2);

    // CNTW=2 saturation, then asynchronous reset with a held result
    step(); c2.in_valid = 1'b1; c2.sel = 3'd6; c2.value = 1'b1;
    repeat (5) step();
    c2.sel = 3'd7; c2.out_ready = 1'b0;
    step(); c2.in_valid = 1'b0;
    @(negedge clk);
    check("c2_saturate", {30'd0, c2.err_cnt}, 32'd3);
    check("c2_held_valid", {31'd0, c2.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, c2.out_valid}, 32'd0);
    check("async_rst_cnt", {30'd0, c2.err_cnt}, 32'd0);
    check("async_rst_in_ready", {31'd0, c2.in_ready}, 32'd1);
    check("async_rst_err", {31'd0, c2.err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
